// File: rtl/gray_updown_counter_if.sv
// Control and status bundle for gray_updown_counter: step/load controls in,
// binary and Gray count plus terminal-count flag out.
interface gray_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             tc;

    modport master (
        output en, up, load, load_gray,
        input  bin_out, gray_out, tc
    );

    modport slave (
        input  en, up, load, load_gray,
        output bin_out, gray_out, tc
    );
endinterface

// File: rtl/gray_updown_counter.sv
// Up/down counter held in binary, presented in binary and Gray, loadable from a
// Gray value, with wrap or saturate behaviour at the limits.
module gray_updown_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    gray_updown_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_CNT = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] gray_reg;
    logic             tc_reg;
    logic             tc_next;
    logic [WIDTH-1:0] load_bin;

    // Gray->binary: each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
            assign load_bin[gi] = ^bus.load_gray[WIDTH-1:gi];
        end
    endgenerate

    always_comb begin
        cnt_next = cnt_reg;
        tc_next  = 1'b0;
        if (bus.load) begin
            cnt_next = load_bin;
        end else if (bus.en) begin
            if (bus.up) begin
                if (cnt_reg == MAX_CNT) begin
                    tc_next = 1'b1;
                    if (WRAP) cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end else begin
                if (cnt_reg == '0) begin
                    tc_next = 1'b1;
                    if (WRAP) cnt_next = MAX_CNT;
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end
        end
    end

    // Gray is registered from the same next value so both outputs always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            gray_reg <= '0;
            tc_reg   <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            gray_reg <= cnt_next ^ (cnt_next >> 1);
            tc_reg   <= tc_next;
        end
    end

    assign bus.bin_out  = cnt_reg;
    assign bus.gray_out = gray_reg;
    assign bus.tc       = tc_reg;
endmodule

// File: tb/tb_gray_updown_counter.sv
// Drives three counters (4-bit wrap, 4-bit saturate, 8-bit wrap) with shared
// directed stimulus and checks them against an arithmetic model every cycle.
module tb_gray_updown_counter;
    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, load;
    logic [7:0] lg;

    int n_checks = 0;
    int n_fail   = 0;

    gray_updown_counter_if #(.WIDTH(4)) if_w ();
    gray_updown_counter_if #(.WIDTH(4)) if_s ();
    gray_updown_counter_if #(.WIDTH(8)) if_8 ();

    assign if_w.en = en;  assign if_w.up = up;  assign if_w.load = load;  assign if_w.load_gray = lg[3:0];
    assign if_s.en = en;  assign if_s.up = up;  assign if_s.load = load;  assign if_s.load_gray = lg[3:0];
    assign if_8.en = en;  assign if_8.up = up;  assign if_8.load = load;  assign if_8.load_gray = lg;

    gray_updown_counter #(.WIDTH(4), .WRAP(1'b1)) dut_w (.clk(clk), .rst(rst), .bus(if_w));
    gray_updown_counter #(.WIDTH(4), .WRAP(1'b0)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
    gray_updown_counter #(.WIDTH(8), .WRAP(1'b1)) dut_8 (.clk(clk), .rst(rst), .bus(if_8));

    always #5 clk = ~clk;

    logic [7:0] bin_a [3];
    logic [7:0] gray_a[3];
    logic       tc_a  [3];
    assign bin_a[0] = {4'b0, if_w.bin_out};  assign gray_a[0] = {4'b0, if_w.gray_out};  assign tc_a[0] = if_w.tc;
    assign bin_a[1] = {4'b0, if_s.bin_out};  assign gray_a[1] = {4'b0, if_s.gray_out};  assign tc_a[1] = if_s.tc;
    assign bin_a[2] = if_8.bin_out;          assign gray_a[2] = if_8.gray_out;          assign tc_a[2] = if_8.tc;

    // Per-counter model: width, wrap mode, expected count, tc, and whether the last edge was a +/-1 step.
    int wd[3] = '{4, 4, 8};
    bit wr[3] = '{1'b1, 1'b0, 1'b1};
    int m_cnt[3] = '{0, 0, 0};
    int m_tc[3]  = '{0, 0, 0};
    bit m_step[3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] prev_gray[3];
    bit chk_on = 1'b0;

    // Binary value whose Gray image is g, found by search rather than by formula.
    function automatic int model_load(int w, int g);
        for (int b = 0; b < (1 << w); b++)
            if ((b ^ (b >> 1)) == g) return b;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            int mx;
            mx = (1 << wd[k]) - 1;
            m_step[k] = 1'b0;
            if (rst) begin
                m_cnt[k] = 0;
                m_tc[k]  = 0;
            end else begin
                m_tc[k] = 0;
                if (load) begin
                    m_cnt[k] = model_load(wd[k], int'(lg) & mx);
                end else if (en && up) begin
                    if (m_cnt[k] == mx) begin
                        m_tc[k] = 1;
                        if (wr[k]) begin m_cnt[k] = 0; m_step[k] = 1'b1; end
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1; m_step[k] = 1'b1;
                    end
                end else if (en) begin
                    if (m_cnt[k] == 0) begin
                        m_tc[k] = 1;
                        if (wr[k]) begin m_cnt[k] = mx; m_step[k] = 1'b1; end
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1; m_step[k] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("dut%0d bin", k), int'(bin_a[k]), m_cnt[k]);
                check($sformatf("dut%0d gray", k), int'(gray_a[k]), m_cnt[k] ^ (m_cnt[k] >> 1));
                check($sformatf("dut%0d tc", k), int'(tc_a[k]), m_tc[k]);
                if (m_step[k])
                    check($sformatf("dut%0d gray one-bit", k), $countones(gray_a[k] ^ prev_gray[k]), 1);
                prev_gray[k] = gray_a[k];
            end
        end
    end

    // Apply inputs just after a falling edge; return at the next falling edge with outputs settled.
    task automatic drive(input logic l, input logic e, input logic u, input logic [7:0] g);
        #1;
        load = l; en = e; up = u; lg = g;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; lg = 8'h00;
        repeat (2) @(negedge clk);
        check("reset bin", int'(if_w.bin_out), 0);
        check("reset gray", int'(if_w.gray_out), 0);
        check("reset tc", int'(if_w.tc), 0);
        chk_on = 1'b1;
        rst = 1'b0;

        drive(1'b1, 1'b0, 1'b0, 8'h0B);
        check("load bin", int'(if_w.bin_out), 13);
        check("load gray", int'(if_w.gray_out), 4'b1011);
        check("load tc", int'(if_w.tc), 0);

        drive(1'b0, 1'b1, 1'b1, 8'h00);
        check("wrap up 14 gray", int'(if_w.gray_out), 4'b1001);
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        check("wrap up 15 gray", int'(if_w.gray_out), 4'b1000);
        check("wrap up 15 tc", int'(if_w.tc), 0);
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        check("wrap up 0 bin", int'(if_w.bin_out), 0);
        check("wrap up 0 tc", int'(if_w.tc), 1);
        check("sat up hold bin", int'(if_s.bin_out), 15);
        check("sat up hold tc", int'(if_s.tc), 1);

        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check("sat down 1 bin", int'(if_s.bin_out), 0);
        check("sat down 1 tc", int'(if_s.tc), 1);
        check("wrap down bin", int'(if_w.bin_out), 15);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check("sat down 2 bin", int'(if_s.bin_out), 0);
        check("sat down 2 tc", int'(if_s.tc), 1);
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        check("sat release bin", int'(if_s.bin_out), 1);
        check("sat release gray", int'(if_s.gray_out), 4'b0001);
        check("sat release tc", int'(if_s.tc), 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("hold bin", int'(if_s.bin_out), 1);

        drive(1'b1, 1'b1, 1'b1, 8'h06);
        check("priority bin", int'(if_w.bin_out), 4);
        drive(1'b1, 1'b0, 1'b0, 8'h08);
        drive(1'b1, 1'b1, 1'b1, 8'h08);
        check("load at limit bin", int'(if_w.bin_out), 15);
        check("load at limit tc", int'(if_w.tc), 0);

        drive(1'b1, 1'b0, 1'b0, 8'h0D);
        check("preset 9 bin", int'(if_w.bin_out), 9);
        #1; load = 1'b0; en = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst bin", int'(if_w.bin_out), 0);
        check("async rst gray", int'(if_w.gray_out), 0);
        check("async rst bin8", int'(if_8.bin_out), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        check("post rst step", int'(if_w.bin_out), 1);

        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 257; i++) drive(1'b0, 1'b1, 1'b1, 8'h00);
        check("sweep up bin8", int'(if_8.bin_out), 1);
        for (int i = 0; i < 257; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);
        check("sweep down bin8", int'(if_8.bin_out), 0);
        check("sweep down bin4", int'(if_w.bin_out), 0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
